// File: rtl/poly_phase_accumulator.sv
// Time-multiplexed per-voice phase accumulator driven by note-on/off commands; one voice per slot.
// Latency: outputs registered 1 cycle after the slot. No backpressure: commands are always accepted.
module poly_phase_accumulator #(
    parameter int NUM_VOICES  = 4,
    parameter int PHASE_WIDTH = 32,
    parameter int CLK_HZ      = 100000000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   cmd_valid_in,
    input  logic                   cmd_on_in,
    input  logic [3:0]             cmd_voice_in,
    input  logic [6:0]             cmd_note_in,
    output logic                   cmd_err_out,
    output logic                   phase_valid_out,
    output logic [3:0]             phase_voice_out,
    output logic [PHASE_WIDTH-1:0] phase_value_out,
    output logic                   phase_active_out,
    output logic                   frame_start_out,
    output logic [NUM_VOICES-1:0]  voice_active_out
);

    localparam int SW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef logic [PHASE_WIDTH-1:0] phase_t;

    // Top-octave (notes 120..131) increments; lower octaves are right shifts of these.
    function automatic logic [12*PHASE_WIDTH-1:0] calc_base_table();
        logic [12*PHASE_WIDTH-1:0] tbl;
        real                       step;
        tbl = '0;
        for (int k = 0; k < 12; k++) begin
            step = 440.0 * (2.0 ** (real'(51 + k) / 12.0)) * (2.0 ** real'(PHASE_WIDTH))
                   * real'(NUM_VOICES) / real'(CLK_HZ);
            tbl[k*PHASE_WIDTH +: PHASE_WIDTH] = PHASE_WIDTH'(longint'(step));
        end
        return tbl;
    endfunction

    localparam logic [12*PHASE_WIDTH-1:0] BASE_TABLE = calc_base_table();

    phase_t                phase [NUM_VOICES];
    phase_t                inc   [NUM_VOICES];
    logic [NUM_VOICES-1:0] active;
    logic [SW-1:0]         slot;

    logic [3:0]    semitone;
    logic [3:0]    octave;
    phase_t        note_inc;
    logic          cmd_ok;
    logic [SW-1:0] cmd_idx;
    logic          slot_hit;
    phase_t        slot_sum;
    phase_t        slot_phase_nxt;
    logic          slot_active_nxt;

    always_comb begin
        semitone = 4'(cmd_note_in % 7'd12);
        octave   = 4'(cmd_note_in / 7'd12);
        note_inc = BASE_TABLE[semitone*PHASE_WIDTH +: PHASE_WIDTH] >> (4'd10 - octave);
    end

    always_comb begin
        cmd_ok   = cmd_valid_in && ({1'b0, cmd_voice_in} < 5'(NUM_VOICES));
        cmd_idx  = SW'(cmd_voice_in);
        slot_hit = cmd_ok && (cmd_idx == slot);
        slot_sum = phase[slot] + (active[slot] ? inc[slot] : '0);
        // A command to the voice being serviced overrides that slot's accumulate.
        slot_phase_nxt  = slot_hit ? '0 : slot_sum;
        slot_active_nxt = slot_hit ? cmd_on_in : active[slot];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            slot   <= '0;
            active <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v] <= '0;
                inc[v]   <= '0;
            end
            cmd_err_out      <= 1'b0;
            phase_valid_out  <= 1'b0;
            phase_voice_out  <= '0;
            phase_value_out  <= '0;
            phase_active_out <= 1'b0;
            frame_start_out  <= 1'b0;
        end else begin
            slot <= (slot == SW'(NUM_VOICES - 1)) ? '0 : slot + 1'b1;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (cmd_ok && (cmd_idx == SW'(v))) begin
                    phase[v]  <= '0;
                    inc[v]    <= cmd_on_in ? note_inc : '0;
                    active[v] <= cmd_on_in;
                end else if (slot == SW'(v)) begin
                    phase[v] <= slot_sum;
                end
            end
            cmd_err_out      <= cmd_valid_in && !cmd_ok;
            phase_valid_out  <= 1'b1;
            phase_voice_out  <= 4'(slot);
            phase_value_out  <= slot_phase_nxt;
            phase_active_out <= slot_active_nxt;
            frame_start_out  <= (slot == '0);
        end
    end

    assign voice_active_out = active;

endmodule

// File: tb/tb_poly_phase_accumulator.sv
// Directed plus random stimulus against an edge-counting model of voice phases.
module tb_poly_phase_accumulator;

    localparam int NV = 4;
    localparam int PW = 32;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          cmd_valid_in;
    logic          cmd_on_in;
    logic [3:0]    cmd_voice_in;
    logic [6:0]    cmd_note_in;
    logic          cmd_err_out;
    logic          phase_valid_out;
    logic [3:0]    phase_voice_out;
    logic [PW-1:0] phase_value_out;
    logic          phase_active_out;
    logic          frame_start_out;
    logic [NV-1:0] voice_active_out;

    always #5 clk_in = ~clk_in;

    poly_phase_accumulator #(.NUM_VOICES(NV), .PHASE_WIDTH(PW), .CLK_HZ(100000000)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .cmd_valid_in     (cmd_valid_in),
        .cmd_on_in        (cmd_on_in),
        .cmd_voice_in     (cmd_voice_in),
        .cmd_note_in      (cmd_note_in),
        .cmd_err_out      (cmd_err_out),
        .phase_valid_out  (phase_valid_out),
        .phase_voice_out  (phase_voice_out),
        .phase_value_out  (phase_value_out),
        .phase_active_out (phase_active_out),
        .frame_start_out  (frame_start_out),
        .voice_active_out (voice_active_out)
    );

    int     checks   = 0;
    int     failures = 0;
    int     edge_n   = 0;
    int     e0       = 0;
    longint base_tbl [12];
    longint m_inc    [NV];
    int     m_ton    [NV];
    bit     m_act    [NV];
    bit     m_err;

    // Model: a voice's phase is its increment times the number of its slots since the note-on edge.
    function automatic longint note_inc(int n);
        return base_tbl[n % 12] >> (10 - n / 12);
    endfunction

    function automatic longint slots_upto(int v, int x);
        return longint'((x - e0 - v + NV) / NV);
    endfunction

    function automatic longint model_phase(int v, int t);
        longint cnt;
        if (!m_act[v]) return 0;
        cnt = slots_upto(v, t) - slots_upto(v, m_ton[v]);
        return (m_inc[v] * cnt) & 64'hFFFF_FFFF;
    endfunction

    function automatic logic [NV-1:0] model_flags();
        logic [NV-1:0] f;
        for (int v = 0; v < NV; v++) f[v] = m_act[v];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, phase_valid_out, 0);
        chk({tag, "_voice"}, phase_voice_out, 0);
        chk({tag, "_phase"}, phase_value_out, 0);
        chk({tag, "_active"}, phase_active_out, 0);
        chk({tag, "_frame"}, frame_start_out, 0);
        chk({tag, "_err"}, cmd_err_out, 0);
        chk({tag, "_vact"}, voice_active_out, 0);
    endtask

    task automatic cycle();
        bit c_v, c_on;
        int c_voice, c_note, s;
        c_v     = cmd_valid_in;
        c_on    = cmd_on_in;
        c_voice = int'(cmd_voice_in);
        c_note  = int'(cmd_note_in);
        @(posedge clk_in);
        edge_n++;
        m_err = c_v && (c_voice >= NV);
        if (c_v && (c_voice < NV)) begin
            m_inc[c_voice] = c_on ? note_inc(c_note) : 0;
            m_act[c_voice] = c_on;
            m_ton[c_voice] = edge_n;
        end
        @(negedge clk_in);
        s = (edge_n - e0) % NV;
        chk("valid", phase_valid_out, 1);
        chk("voice", phase_voice_out, s);
        chk("phase", phase_value_out, model_phase(s, edge_n));
        chk("active", phase_active_out, m_act[s]);
        chk("frame", frame_start_out, s == 0);
        chk("err", cmd_err_out, m_err);
        chk("vact", voice_active_out, model_flags());
    endtask

    task automatic cmd(input bit on, input int voice, input int note);
        cmd_valid_in = 1'b1;
        cmd_on_in    = on;
        cmd_voice_in = 4'(voice);
        cmd_note_in  = 7'(note);
        cycle();
        cmd_valid_in = 1'b0;
        cmd_on_in    = 1'b0;
        cmd_voice_in = '0;
        cmd_note_in  = '0;
    endtask

    task automatic wait_slot(input int v);
        int n = 0;
        do begin
            cycle();
            n++;
        end while ((int'(phase_voice_out) != v) && (n < 2 * NV));
        chk("wait_slot", phase_voice_out, v);
    endtask

    // Called at a falling edge; holds reset across one rising edge.
    task automatic do_reset();
        rst_in = 1'b0;
        #1;
        chk_all_zero("rst");
        @(posedge clk_in);
        edge_n++;
        @(negedge clk_in);
        chk_all_zero("rst_hold");
        cmd_valid_in = 1'b0;
        cmd_on_in    = 1'b0;
        cmd_voice_in = '0;
        cmd_note_in  = '0;
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 1'b0;
            m_inc[v] = 0;
            m_ton[v] = 0;
        end
        m_err  = 1'b0;
        rst_in = 1'b1;
        e0     = edge_n + 1;
    endtask

    initial begin
        logic [PW-1:0] prev;
        bit            wrapped;
        for (int k = 0; k < 12; k++)
            base_tbl[k] = longint'($rtoi(440.0 * (2.0 ** ((51.0 + k) / 12.0))
                                         * 4294967296.0 * 4.0 / 100000000.0 + 0.5));
        rst_in       = 1'b0;
        cmd_valid_in = 1'b0;
        cmd_on_in    = 1'b0;
        cmd_voice_in = '0;
        cmd_note_in  = '0;
        @(negedge clk_in);
        do_reset();

        // First edge after reset is slot 0: the note-on collides with its own slot.
        cmd(1'b1, 0, 60);
        chk("coll_phase", phase_value_out, 0);
        chk("coll_active", phase_active_out, 1);
        wait_slot(0);
        chk("n60_f1", phase_value_out, 44946);
        wait_slot(0);
        chk("n60_f2", phase_value_out, 89892);
        wait_slot(0);
        chk("n60_f3", phase_value_out, 134838);

        cmd(1'b0, 0, 0);
        while (((edge_n + 1 - e0) % NV) == 2) cycle();
        cmd(1'b1, 2, 69);
        repeat (3) wait_slot(2);
        chk("n69_phase", phase_value_out, 226773);
        chk("n69_active", phase_active_out, 1);
        chk("n69_vact", voice_active_out, 4'b0100);

        cmd(1'b1, 5, 10);
        chk("bad_err", cmd_err_out, 1);
        chk("bad_vact", voice_active_out, 4'b0100);
        cycle();
        chk("bad_err_clear", cmd_err_out, 0);

        cmd(1'b1, 1, 127);
        prev    = '0;
        wrapped = 1'b0;
        repeat (8400) begin
            cycle();
            if (phase_voice_out == 4'd1) begin
                if (phase_value_out < prev) wrapped = 1'b1;
                prev = phase_value_out;
            end
        end
        chk("wrap_seen", wrapped, 1);

        repeat (600) begin
            cmd_valid_in = ($urandom_range(0, 2) == 0);
            cmd_on_in    = ($urandom_range(0, 3) != 0);
            cmd_voice_in = 4'($urandom_range(0, 7));
            cmd_note_in  = 7'($urandom_range(0, 127));
            cycle();
        end
        cmd_valid_in = 1'b0;

        for (int v = 0; v < NV; v++) cmd(1'b1, v, 40 + 7 * v);
        repeat (6) cycle();
        chk("pre_rst_vact", voice_active_out, 4'b1111);
        cycle();
        cmd_valid_in = 1'b1;
        cmd_on_in    = 1'b1;
        cmd_voice_in = 4'd3;
        cmd_note_in  = 7'd50;
        do_reset();
        cycle();
        chk("post_frame", frame_start_out, 1);
        chk("post_voice", phase_voice_out, 0);
        chk("post_phase", phase_value_out, 0);
        repeat (8) cycle();
        chk("post_vact", voice_active_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
